// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default operand width and its matching iteration-counter width
   localparam int DIV_N = 32;
   localparam int CNT_W = $clog2(DIV_N);

   // Operation select codes understood by the alu
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_OR  = 2'd3;

   // Counter width for an arbitrary operand width; never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu.sv
// Small combinational ALU. For subtraction, C is the borrow (A < B).
module alu
   import div_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [1:0]   aluFunc,
   output logic [N-1:0] Y,
   output logic         C
);

   logic [N:0] ext;

   // One extra result bit carries the add carry-out or the subtract borrow
   always_comb begin
      ext = '0;
      case (aluFunc)
         ALU_ADD: ext = {1'b0, A} + {1'b0, B};
         ALU_SUB: ext = {1'b0, A} - {1'b0, B};
         ALU_AND: ext = {1'b0, A & B};
         default: ext = {1'b0, A | B};
      endcase
   end

   assign Y = ext[N-1:0];
   assign C = ext[N];

endmodule

// File: rtl/div_unit.sv
// Sequential unsigned divider, one restoring step per clock.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | one quotient bit produced per cycle, N cycles total
// DONE  | results valid, done pulses for one cycle
module div_unit
   import div_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         Z,
   output logic         dbz
);

   localparam int CW = cnt_width(N);

   state_t         state_q, state_d;
   logic [N-1:0]   dvd_q, dvd_d;
   logic [N-1:0]   dvs_q, dvs_d;
   logic [N-1:0]   r_q, r_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   quot_q, quot_d;
   logic [N-1:0]   rem_q, rem_d;
   logic           z_q, z_d;
   logic           dbz_q, dbz_d;

   logic [N:0]     p;
   logic [N:0]     alu_y;
   logic           alu_c;
   logic [N:0]     r_full;

   // Trial subtraction of the divisor from the shifted partial remainder
   assign p = {r_q, dvd_q[N-1]};

   alu #(.N(N + 1)) u_alu (
      .A       (p),
      .B       ({1'b0, dvs_q}),
      .aluFunc (ALU_SUB),
      .Y       (alu_y),
      .C       (alu_c)
   );

   // On borrow keep P; P[N] can only be set when the subtraction succeeds,
   // so r_full[N] is always zero and the low N bits are the new remainder.
   assign r_full = alu_c ? p : alu_y;

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      z_d     = z_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (b != '0) begin
                  dvd_d   = a;
                  dvs_d   = b;
                  r_d     = '0;
                  cnt_d   = CW'(N - 1);
                  dbz_d   = 1'b0;
                  state_d = RUN;
               end else begin
                  quot_d  = '1;
                  rem_d   = a;
                  z_d     = (a == '0);
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            r_d   = r_full[N-1:0];
            dvd_d = {dvd_q[N-2:0], ~alu_c};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               quot_d  = {dvd_q[N-2:0], ~alu_c};
               rem_d   = r_full[N-1:0];
               z_d     = (r_full == '0);
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         z_q     <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         z_q     <= z_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign Z         = z_q;
   assign dbz       = dbz_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The parameter SHALL be: N, default 32, operand and result width in bits.
REQ-002 The port clk SHALL be: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The port rst SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-004 The port start SHALL be: input, 1 bit, request to begin a division; sampled only in IDLE.
REQ-005 The port a SHALL be: input, N bits, unsigned dividend; captured on an accepted start.
REQ-006 The port b SHALL be: input, N bits, unsigned divisor; captured on an accepted start.
REQ-007 The port busy SHALL be: output, 1 bit, high while in RUN.
REQ-008 The port done SHALL be: output, 1 bit, one-cycle pulse when results become valid.
REQ-009 The port quotient SHALL be: output, N bits, floor(a/b).
REQ-010 The port remainder SHALL be: output, N bits, a mod b.
REQ-011 The port Z SHALL be: output, 1 bit, high when remainder == 0; valid with done and held afterwards.
REQ-012 The port dbz SHALL be: output, 1 bit, divide-by-zero flag; valid with done and held afterwards.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 and b!=0, the block SHALL capture a and b, clear the partial remainder, load an iteration counter with N-1 and enter RUN.
REQ-015 In IDLE with start=1 and b==0, the block SHALL enter DONE directly, setting quotient={N{1}}, remainder=a, dbz=1 and Z=(a==0).
REQ-016 In each RUN cycle, the block SHALL perform one restoring step:
  - partial remainder P (N+1 bits) = {R, dividend MSB};
  - dividend is shifted left;
  - if P >= divisor (no borrow on P-divisor), R = P-divisor and the quotient LSB is 1;
  - else R = P[N-1:0] and the quotient LSB is 0.
REQ-017 The counter SHALL decrement once per RUN cycle; the block SHALL move from RUN to DONE after the step in which the counter equals 0, giving exactly N RUN cycles.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, after which the block returns to IDLE unconditionally.
REQ-019 Latency SHALL be: for b!=0, done asserts N+1 cycles after the start-sampling edge; for b==0, it asserts 1 cycle after that edge.
REQ-020 The outputs quotient, remainder, Z and dbz SHALL update only on entry to DONE and SHALL hold until the next accepted start; dbz SHALL clear on an accepted start with b!=0.
REQ-021 A start asserted in RUN or DONE SHALL be ignored, with no queuing; a start is accepted no earlier than the cycle after done.
REQ-022 Changes to a or b after the start edge SHALL have no effect on the operation in progress.
REQ-023 The quotient SHALL be exact for a < b (quotient=0, remainder=a), for b=1 (quotient=a, remainder=0) and for a=b (quotient=1, remainder=0).

Reset
REQ-024 While rst=1, state SHALL be IDLE and busy, done, Z, dbz, quotient, remainder and the internal registers SHALL be 0.
REQ-025 A reset asserted during RUN SHALL abort the operation immediately, with no done pulse; the first start after reset release SHALL operate normally.

Structure
REQ-026 A shared package div_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the counter-width constant $clog2(N).
REQ-027 The trial subtraction SHALL be one instance of the existing alu module with parameter N+1 and aluFunc=1; its carry output C is the borrow indicator (C=1 means P < divisor, so restore).
REQ-028 No other sub-modules SHALL be used.

Verification
REQ-029 Normal case: a=100, b=7, start for 1 cycle -> busy high for 32 cycles, done at edge 33, quotient=14, remainder=2, Z=0, dbz=0.
REQ-030 Divide by zero: a=5, b=0 -> done at edge 1, quotient=32'hFFFFFFFF, remainder=5, dbz=1, busy never high.
REQ-031 Boundaries:
  - a=3, b=10 -> quotient=0, remainder=3;
  - a=32'hFFFFFFFF, b=1 -> quotient=32'hFFFFFFFF, remainder=0, Z=1;
  - a=b=32'h80000000 -> quotient=1, remainder=0.
REQ-032 Ignored start and input changes: start pulsed at cycles 5 and 32 of a RUN with a=1000, b=3, and a/b changed mid-RUN -> a single done with quotient=333, remainder=1, and no second operation.
REQ-033 Reset mid-RUN: rst at cycle 10 of a RUN -> all outputs 0 and no done; a following a=50, b=5 run -> quotient=10, remainder=0, Z=1.
REQ-034 Randomised check: 1000 random a, b with b!=0 -> quotient*b+remainder==a, remainder<b, and done exactly N+1 cycles after each start.
